// File: rtl/image_uart_pkg.sv
// image_uart_pkg: UART register map and sender state encoding,
// shared by the UART image sender and the UART image loader.
package image_uart_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int TX_OK_BIT = 6;
  localparam int RX_OK_BIT = 7;

  localparam int DEF_BYTE_COUNT = 12288;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_POLL,
    S_WRITE
  } state_t;

endpackage

// File: rtl/image_sender_if.sv
// image_sender_if: Avalon-MM bus toward the UART core.
// master drives address/read/write/writedata; slave returns readdata/waitrequest.
interface image_sender_if;

  logic [4:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: polls UART status for TX space, then writes one byte.
// Ports: clk_i, rst_ni, go_i, byte_i in; tx_ok_o, ack_o, timeout_o pulses; avm master.
module uart_tx_byte
  import image_uart_pkg::*;
#(
  parameter int STATUS_TIMEOUT = 0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           go_i,
  input  logic [7:0]     byte_i,
  output logic           tx_ok_o,
  output logic           ack_o,
  output logic           timeout_o,
  image_sender_if.master avm
);

  localparam int PW =
    (STATUS_TIMEOUT > 1) ? $clog2(STATUS_TIMEOUT) : 1;

  state_t        st_q, st_d;
  logic [PW-1:0] polls_q, polls_d;
  logic [4:0]    addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rd_done, wr_done, last_poll;
  logic          unused_rd;

  assign unused_rd = ^avm.readdata;

  assign avm.address   = addr_q;
  assign avm.read      = rd_q;
  assign avm.write     = wr_q;
  assign avm.writedata = wdata_q;

  assign rd_done = rd_q && !avm.waitrequest;
  assign wr_done = wr_q && !avm.waitrequest;

  // polls_q counts failed polls already completed for this byte
  assign last_poll = (STATUS_TIMEOUT > 0) &&
    (int'(polls_q) == STATUS_TIMEOUT - 1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q    <= S_IDLE;
      polls_q <= '0;
      addr_q  <= STATUS_BASE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      st_q    <= st_d;
      polls_q <= polls_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    polls_d   = polls_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    tx_ok_o   = 1'b0;
    ack_o     = 1'b0;
    timeout_o = 1'b0;
    unique case (1'b1)
      st_q == S_POLL: begin
        if (rd_done && avm.readdata[TX_OK_BIT]) begin
          tx_ok_o = 1'b1;
          st_d    = S_WRITE;
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          addr_d  = TX_BASE;
          wdata_d = {24'h0, byte_i};
        end else if (rd_done && last_poll) begin
          timeout_o = 1'b1;
          st_d      = S_IDLE;
          rd_d      = 1'b0;
          addr_d    = STATUS_BASE;
        end else if (rd_done) begin
          polls_d = polls_q + 1'b1;
        end
      end
      st_q == S_WRITE: begin
        if (wr_done) begin
          ack_o  = 1'b1;
          st_d   = S_IDLE;
          wr_d   = 1'b0;
          addr_d = STATUS_BASE;
        end
      end
      default: begin
        st_d = S_IDLE;
        if (go_i) begin
          st_d    = S_POLL;
          rd_d    = 1'b1;
          addr_d  = STATUS_BASE;
          polls_d = '0;
        end
      end
    endcase
  end

endmodule

// File: rtl/image_sender.sv
// image_sender: streams BYTE_COUNT source bytes to the UART TX register.
// Ports: avm_clk/avm_rst_n, start, in_* stream, avm bus, busy/done/error.
module image_sender
  import image_uart_pkg::*;
#(
  parameter int BYTE_COUNT     = DEF_BYTE_COUNT,
  parameter int STATUS_TIMEOUT = 0
) (
  input  logic           avm_clk,
  input  logic           avm_rst_n,
  input  logic           start,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  image_sender_if.master avm,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam int CW =
    (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTE_COUNT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          go, tx_ok, ack, tmo;

  assign in_ready = (state_q == S_FETCH);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign error    = err_q;
  assign go       = in_ready && in_valid;

  uart_tx_byte #(
    .STATUS_TIMEOUT(STATUS_TIMEOUT)
  ) u_tx (
    .clk_i    (avm_clk),
    .rst_ni   (avm_rst_n),
    .go_i     (go),
    .byte_i   (byte_q),
    .tx_ok_o  (tx_ok),
    .ack_o    (ack),
    .timeout_o(tmo),
    .avm      (avm)
  );

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (1'b1)
      state_q == S_FETCH: begin
        if (in_valid) begin
          byte_d  = in_data;
          state_d = S_POLL;
        end
      end
      state_q == S_POLL: begin
        if (tx_ok) begin
          state_d = S_WRITE;
        end else if (tmo) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      state_q == S_WRITE: begin
        if (ack && cnt_q == LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (ack) begin
          state_d = S_FETCH;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_image_sender.sv
// tb_image_sender: scoreboard bench for image_sender with a
// scripted UART slave (TX_OK failures, stalls) and a byte source.
module tb_image_sender;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] in_data = 8'h0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       busy, done, error;

  image_sender_if avm ();

  image_sender #(
    .BYTE_COUNT    (4),
    .STATUS_TIMEOUT(8)
  ) dut (
    .avm_clk  (clk),
    .avm_rst_n(rst_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .avm      (avm),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  src [4];
  int src_idx = 0, src_n = 0;
  bit hs_pend = 0;
  int fail_n = 0, fail_left = 0;
  bit stuck = 0;
  int stall_arm = 0, stall_left = 0;
  int polls = 0, exp_polls = 1;
  int nwrites = 0;
  int base;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // source and UART slave; acts on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_pend = 0;
      in_valid = 0;
      stall_left = 0;
      avm.waitrequest = 0;
      avm.readdata = 0;
    end else begin
      if (hs_pend) src_idx++;
      hs_pend = 0;
      in_valid = (src_idx < src_n);
      if (in_valid) in_data = src[src_idx];
      if (in_valid && in_ready) begin
        hs_pend = 1;
        exp_q.push_back({24'h0, in_data});
      end
      avm.waitrequest = 0;
      avm.readdata = 0;
      if (avm.read || avm.write)
        chk("rd_wr_excl", avm.read & avm.write, 0);
      if (avm.write && stall_arm > 0) begin
        stall_left = stall_arm;
        stall_arm = 0;
      end
      if (stall_left > 0) begin
        chk("stall_wr", avm.write, 1);
        chk("stall_addr", avm.address, 4);
        chk("stall_data", avm.writedata,
            exp_q.size() > 0 ? exp_q[0] : 32'hDEADBEEF);
        avm.waitrequest = 1;
        stall_left--;
      end else if (avm.write) begin
        chk("wr_q", exp_q.size(), 1);
        chk("wr_addr", avm.address, 4);
        chk("wr_polls", polls, exp_polls);
        if (exp_q.size() > 0)
          chk("wr_data", avm.writedata, exp_q.pop_front());
        nwrites++;
        polls = 0;
        fail_left = fail_n;
      end else if (avm.read) begin
        chk("poll_addr", avm.address, 8);
        avm.readdata = (!stuck && fail_left == 0) ?
          32'h0000_0040 : 32'hFFFF_FFBF;
        if (fail_left > 0) fail_left--;
        polls++;
      end
    end
  end

  task automatic load(input logic [7:0] b0, b1, b2, b3,
                      input int nf);
    src[0] = b0; src[1] = b1;
    src[2] = b2; src[3] = b3;
    src_idx = 0;
    src_n = 4;
    fail_n = nf;
    fail_left = nf;
    exp_polls = nf + 1;
    polls = 0;
  endtask

  // call #1 after a falling edge; start is sampled at the next rising edge
  task automatic run_image(input int exp_cyc,
                           input bit exp_err,
                           input bit poke);
    int cyc;
    bit fin;
    cyc = 0;
    fin = 0;
    start = 1;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
      start = poke && (cyc == exp_cyc - 1);
      if (cyc == 1) begin
        chk("busy_c1", busy, 1);
        chk("rdy_c1", in_ready, 1);
      end
      if (done || error) fin = 1;
    end
    chk("end_seen", fin, 1);
    chk("end_cycle", cyc, exp_cyc);
    chk("done_end", done, !exp_err);
    chk("err_end", error, exp_err);
    chk("busy_end", busy, 0);
    @(negedge clk);
    #1;
    start = 0;
    chk("done_1cyc", done, 0);
    chk("err_1cyc", error, 0);
    chk("busy_after", busy, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_addr"}, avm.address, 8);
    chk({tag, "_rd"}, avm.read, 0);
    chk({tag, "_wr"}, avm.write, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, error, 0);
  endtask

  initial begin
    rst_n = 0;
    start = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("rst");
    chk("rst_wdata", avm.writedata, 0);
    rst_n = 1;
    @(negedge clk);
    #1;

    // always-ready slave, 3 cycles per byte, late start ignored
    load(8'h11, 8'h22, 8'h33, 8'h44, 0);
    base = nwrites;
    run_image(13, 0, 1);
    chk("fast_writes", nwrites - base, 4);
    chk("fast_q", exp_q.size(), 0);

    // first 3 polls of every byte report no TX space
    load(8'hA5, 8'h5A, 8'hC3, 8'h3C, 3);
    base = nwrites;
    run_image(25, 0, 0);
    chk("busy_writes", nwrites - base, 4);
    chk("busy_q", exp_q.size(), 0);

    // first write stalled by waitrequest for 5 cycles
    load(8'h01, 8'h80, 8'hFF, 8'h7E, 0);
    stall_arm = 5;
    base = nwrites;
    run_image(18, 0, 0);
    chk("stall_writes", nwrites - base, 4);
    chk("stall_q", exp_q.size(), 0);

    // TX_OK never set: abort after 8 polls
    load(8'h77, 8'h66, 8'h55, 8'h44, 0);
    stuck = 1;
    base = nwrites;
    run_image(10, 1, 0);
    chk("to_writes", nwrites - base, 0);
    chk("to_polls", polls, 8);
    stuck = 0;
    exp_q.delete();

    // reset during the second byte's poll, then a full image
    load(8'hDE, 8'hAD, 8'hBE, 8'hEF, 0);
    start = 1;
    @(negedge clk);
    #1;
    start = 0;
    repeat (4) @(negedge clk);
    #1;
    rst_n = 0;
    @(negedge clk);
    #1;
    chk_idle("mid");
    rst_n = 1;
    exp_q.delete();
    load(8'h0F, 8'hF0, 8'h3C, 8'hC3, 0);
    base = nwrites;
    run_image(13, 0, 0);
    chk("rst_writes", nwrites - base, 4);
    chk("rst_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
